// File: rtl/tdm_pkg.sv
// Shared definitions for the 4-channel TDM link (demux side and serializer side).
//   tdm_state_e : framing state, HUNT (looking for SOF) or LOCKED (slot-aligned)
//   NUM_CH      : channels per frame
//   slot_t      : slot index within a frame
//   ch_lsb()    : bit offset of channel k in a flat {ch3,ch2,ch1,ch0} bus
//   slot_onehot : one-hot channel strobe for a slot index
package tdm_pkg;

    localparam int NUM_CH = 4;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } tdm_state_e;

    typedef logic [1:0] slot_t;

    // Channel k lives at [k*w +: w]; channel 0 in the least significant lane.
    function automatic int ch_lsb(input slot_t k, input int w);
        return int'(k) * w;
    endfunction

    function automatic logic [NUM_CH-1:0] slot_onehot(input slot_t k);
        logic [NUM_CH-1:0] oh;
        oh    = '0;
        oh[k] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// 2-bit wrapping slot counter shared by both ends of the TDM link.
//   clk, rst_n : clock, async active-low reset (slot -> 0)
//   clr        : drop to slot 0 (loss of lock)
//   load1      : resync, the current beat was slot 0 so the next is slot 1
//   inc        : advance one slot, wrapping 3 -> 0
//   slot       : current slot index
// Priority is clr > load1 > inc.
module tdm_slot_ctr
    import tdm_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  clr,
    input  logic  load1,
    input  logic  inc,
    output slot_t slot
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     slot <= '0;
        else if (clr)   slot <= '0;
        else if (load1) slot <= slot_t'(1);
        else if (inc)   slot <= slot + slot_t'(1);
    end

endmodule

// File: rtl/tdm_demux4.sv
// 1-to-4 TDM demultiplexer: receive end of a 4-channel TDM serializer.
// Recovers slot alignment from the SOF marker, routes each beat to its
// channel register and publishes a full-frame snapshot when slot 3 lands.
//   clk, rst_n  : clock, async active-low reset
//   in_valid    : beat present (beats with in_valid=0 are ignored)
//   in_data     : sample for the current slot
//   in_sof      : marks the slot-0 beat, qualified by in_valid
//   ch_data     : last sample per channel, channel k at [k*DATA_W +: DATA_W]
//   ch_valid    : one-cycle strobe, bit k when channel k updated
//   frame_data  : last complete frame, same packing as ch_data
//   frame_valid : one-cycle strobe when frame_data updates
//   locked      : high while slot-aligned
//   sync_err    : one-cycle strobe on a framing error
//   err_cnt     : saturating framing-error count, cleared only by reset
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ERR_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_sof,
    output logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [NUM_CH-1:0]        ch_valid,
    output logic [NUM_CH*DATA_W-1:0] frame_data,
    output logic                     frame_valid,
    output logic                     locked,
    output logic                     sync_err,
    output logic [ERR_W-1:0]         err_cnt
);

    tdm_state_e state_q, state_d;
    slot_t      slot;

    logic  cap_en;
    slot_t cap_slot;
    logic  frame_done;
    logic  err;
    logic  ctr_clr, ctr_load1, ctr_inc;

    // Slots 0..2 of the frame in progress; slot 3 comes straight from in_data.
    logic [NUM_CH-2:0][DATA_W-1:0] stage_q;

    tdm_slot_ctr u_slot_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (ctr_clr),
        .load1 (ctr_load1),
        .inc   (ctr_inc),
        .slot  (slot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= HUNT;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        cap_en     = 1'b0;
        cap_slot   = slot;
        frame_done = 1'b0;
        err        = 1'b0;
        ctr_clr    = 1'b0;
        ctr_load1  = 1'b0;
        ctr_inc    = 1'b0;
        if (in_valid) begin
            if (state_q == HUNT) begin
                // Non-SOF beats while hunting are dropped silently.
                if (in_sof) begin
                    cap_en    = 1'b1;
                    cap_slot  = '0;
                    ctr_load1 = 1'b1;
                    state_d   = LOCKED;
                end
            end else if (in_sof && slot != '0) begin
                // Early SOF: abandon the partial frame and resync on this beat.
                // Old staging is harmless, it is rewritten before slot 3 can publish.
                err       = 1'b1;
                cap_en    = 1'b1;
                cap_slot  = '0;
                ctr_load1 = 1'b1;
            end else if (!in_sof && slot == '0) begin
                // Missing SOF: alignment is lost, drop the beat and hunt again.
                err     = 1'b1;
                ctr_clr = 1'b1;
                state_d = HUNT;
            end else begin
                cap_en     = 1'b1;
                ctr_inc    = 1'b1;
                frame_done = (slot == slot_t'(NUM_CH-1));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_data     <= '0;
            ch_valid    <= '0;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            err_cnt     <= '0;
            stage_q     <= '0;
        end else begin
            ch_valid    <= cap_en ? slot_onehot(cap_slot) : '0;
            frame_valid <= frame_done;
            sync_err    <= err;
            if (cap_en) begin
                ch_data[ch_lsb(cap_slot, DATA_W) +: DATA_W] <= in_data;
                if (cap_slot != slot_t'(NUM_CH-1))
                    stage_q[cap_slot] <= in_data;
            end
            if (frame_done)
                frame_data <= {in_data, stage_q[2], stage_q[1], stage_q[0]};
            if (err && err_cnt != '1)
                err_cnt <= err_cnt + ERR_W'(1);
        end
    end

    assign locked = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demux4.sv
module tb_tdm_demux4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_sof = 1'b0;
    logic [DW-1:0] in_data = '0;

    logic [4*DW-1:0] ch_data, frame_data, s_ch_data, s_frame_data;
    logic [3:0]      ch_valid, s_ch_valid;
    logic            frame_valid, locked, sync_err;
    logic            s_frame_valid, s_locked, s_sync_err;
    logic [7:0]      err_cnt;
    logic [1:0]      s_err_cnt;

    always #5 clk = ~clk;

    tdm_demux4 #(.DATA_W(DW), .ERR_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof),
        .ch_data(ch_data), .ch_valid(ch_valid), .frame_data(frame_data),
        .frame_valid(frame_valid), .locked(locked), .sync_err(sync_err), .err_cnt(err_cnt)
    );

    // Same stimulus into a narrow-counter copy to exercise saturation.
    tdm_demux4 #(.DATA_W(DW), .ERR_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof),
        .ch_data(s_ch_data), .ch_valid(s_ch_valid), .frame_data(s_frame_data),
        .frame_valid(s_frame_valid), .locked(s_locked), .sync_err(s_sync_err), .err_cnt(s_err_cnt)
    );

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Reference model: a frame is the queue of beats collected since the last SOF.
    logic [DW-1:0] m_ch [4];
    logic [DW-1:0] m_q [$];
    logic [3:0]    m_chv;
    logic [31:0]   m_frame;
    bit            m_fv, m_lock, m_serr;
    int            m_err;

    task automatic model_reset();
        for (int k = 0; k < 4; k++) m_ch[k] = '0;
        m_q.delete();
        m_chv = '0; m_frame = '0; m_fv = 0; m_lock = 0; m_serr = 0; m_err = 0;
    endtask

    task automatic model_step();
        m_chv = '0; m_fv = 0; m_serr = 0;
        if (!in_valid) return;
        if (!m_lock) begin
            if (in_sof) begin
                m_lock = 1; m_q = {in_data}; m_ch[0] = in_data; m_chv = 4'b0001;
            end
        end else if (in_sof && m_q.size() != 0) begin
            m_serr = 1; m_err++;
            m_q = {in_data}; m_ch[0] = in_data; m_chv = 4'b0001;
        end else if (!in_sof && m_q.size() == 0) begin
            m_serr = 1; m_err++; m_lock = 0;
        end else begin
            m_ch[m_q.size()] = in_data;
            m_chv = 4'b0001 << m_q.size();
            m_q.push_back(in_data);
            if (m_q.size() == 4) begin
                m_frame = {m_q[3], m_q[2], m_q[1], m_q[0]};
                m_fv = 1;
                m_q.delete();
            end
        end
    endtask

    function automatic int sat(input int n, input int mx);
        return (n > mx) ? mx : n;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ch_data",     ch_data,     {m_ch[3], m_ch[2], m_ch[1], m_ch[0]});
            chk("ch_valid",    32'(ch_valid), 32'(m_chv));
            chk("frame_data",  frame_data,  m_frame);
            chk("frame_valid", 32'(frame_valid), 32'(m_fv));
            chk("locked",      32'(locked),   32'(m_lock));
            chk("sync_err",    32'(sync_err), 32'(m_serr));
            chk("err_cnt",     32'(err_cnt),  32'(sat(m_err, 255)));
            chk("sat_err_cnt", 32'(s_err_cnt), 32'(sat(m_err, 3)));
            chk("sat_frame",   s_frame_data, m_frame);
        end
    end

    // One clock: drive at negedge, model follows the posedge, return at next negedge.
    task automatic cyc(input bit v, input bit sof, input logic [DW-1:0] d);
        in_valid = v; in_sof = sof; in_data = d;
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_step();
        @(negedge clk);
    endtask

    task automatic frame4(input logic [DW-1:0] base);
        for (int k = 0; k < 4; k++) cyc(1, k == 0, base + DW'(k));
    endtask

    int sat_exp [5] = '{1, 2, 3, 3, 3};
    int rp = 0;

    initial begin
        #1 rst_n = 1'b0;
        model_reset();
        chk_en = 1'b1;
        cyc(0, 0, 0); cyc(0, 0, 0);
        chk("rst_ch_data", ch_data, 32'h0);
        chk("rst_locked", 32'(locked), 32'h0);
        chk("rst_err_cnt", 32'(err_cnt), 32'h0);
        rst_n = 1'b1;

        // Hunt discard
        cyc(1, 0, 8'h55); cyc(1, 0, 8'h66);
        chk("hunt_ch_data", ch_data, 32'h0);
        chk("hunt_locked", 32'(locked), 32'h0);
        chk("hunt_err", 32'(err_cnt), 32'h0);

        // Continuous frames A, B
        cyc(1, 1, 8'h10);
        chk("a0_locked", 32'(locked), 32'h1);
        chk("a0_chv", 32'(ch_valid), 32'h1);
        cyc(1, 0, 8'h11); chk("a1_chv", 32'(ch_valid), 32'h2);
        cyc(1, 0, 8'h12); chk("a2_chv", 32'(ch_valid), 32'h4);
        cyc(1, 0, 8'h13); chk("a3_chv", 32'(ch_valid), 32'h8);
        chk("a_frame", frame_data, 32'h13121110);
        chk("a_fv", 32'(frame_valid), 32'h1);
        frame4(8'h20);
        chk("b_frame", frame_data, 32'h23222120);

        // Early SOF
        cyc(1, 1, 8'h10); cyc(1, 0, 8'h11); cyc(1, 1, 8'h20);
        chk("esof_serr", 32'(sync_err), 32'h1);
        chk("esof_cnt", 32'(err_cnt), 32'h1);
        chk("esof_fv", 32'(frame_valid), 32'h0);
        cyc(1, 0, 8'h21); cyc(1, 0, 8'h22); cyc(1, 0, 8'h23);
        chk("esof_frame", frame_data, 32'h23222120);
        chk("esof_fv2", 32'(frame_valid), 32'h1);

        // Missing SOF
        frame4(8'h40);
        cyc(1, 0, 8'h30);
        chk("msof_serr", 32'(sync_err), 32'h1);
        chk("msof_locked", 32'(locked), 32'h0);
        chk("msof_ch0", ch_data, 32'h43424140);
        chk("msof_cnt", 32'(err_cnt), 32'h2);

        // Relock, with a two-cycle gap inside the frame
        cyc(1, 1, 8'h50);
        chk("relock", 32'(locked), 32'h1);
        cyc(0, 0, 8'hEE); cyc(0, 1, 8'hEF);
        cyc(1, 0, 8'h51); cyc(1, 0, 8'h52); cyc(1, 0, 8'h53);
        chk("gap_frame", frame_data, 32'h53525150);

        // Async reset after slot 2
        cyc(1, 1, 8'h60); cyc(1, 0, 8'h61); cyc(1, 0, 8'h62);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_ch_data", ch_data, 32'h0);
        chk("arst_frame", frame_data, 32'h0);
        chk("arst_locked", 32'(locked), 32'h0);
        chk("arst_cnt", 32'(err_cnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        frame4(8'h70);
        chk("post_rst_frame", frame_data, 32'h73727170);

        // Saturation on the 2-bit counter
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 8'h84);
            chk("sat_cnt", 32'(s_err_cnt), 32'(sat_exp[i]));
            chk("wide_cnt", 32'(err_cnt), 32'(i + 1));
            frame4(8'h80);
        end

        // Random traffic: mostly well-framed, with gaps and occasional framing faults
        for (int i = 0; i < 2000; i++) begin
            bit v, sof;
            v   = ($urandom % 10) < 7;
            sof = (rp == 0) ^ (($urandom % 12) == 0);
            if (v) rp = sof ? 1 : (rp + 1) % 4;
            cyc(v, sof, DW'($urandom));
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- 1-to-4 time-division demultiplexer; the receive end of a 4-channel TDM serializer.
- Accepts one interleaved beat per valid cycle and uses a frame-start marker to recover slot alignment.
- Routes each beat to its channel register and publishes a coherent 4-channel frame snapshot once all slots arrive.
- Sits between the TDM link and the per-channel consumers.

Parameters:
- DATA_W, 8, width of one channel sample.
- ERR_W, 8, width of the saturating framing-error counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  beat present this cycle; beats with in_valid=0 are ignored entirely.
- in_data  input  DATA_W  sample for current slot.
- in_sof  input  1  qualified by in_valid; marks the slot-0 beat of a frame.
- ch_data  output  4*DATA_W  per-channel last sample; channel k at [k*DATA_W +: DATA_W].
- ch_valid  output  4  one-cycle pulse; bit k set when ch_data channel k updated.
- frame_data  output  4*DATA_W  snapshot of a complete frame, same packing as ch_data.
- frame_valid  output  1  one-cycle pulse when frame_data updates.
- locked  output  1  high in LOCKED state.
- sync_err  output  1  one-cycle pulse on a framing error.
- err_cnt  output  ERR_W  saturating count of framing errors.

Behaviour:
- Reset (async assert, sync deassert by clk): state=HUNT, slot=0, all outputs 0.
- State machine has two states, HUNT and LOCKED, plus a 2-bit slot counter and 3 staging registers for slots 0..2.
- HUNT:
  - Valid beat with in_sof=1: capture as slot 0, go to LOCKED, slot<=1.
  - Valid beat with in_sof=0: discard; no outputs change and it is not an error.
- LOCKED, valid beat, in_sof matches slot (in_sof=1 iff slot==0): normal capture.
  - ch_data[slot] <= in_data.
  - ch_valid[slot] pulses next cycle.
  - slot increments, wrapping 3->0.
- Slot 3 capture:
  - frame_data <= {in_data, staged slot2, staged slot1, staged slot0}, all four updated in the same cycle.
  - frame_valid pulses in the same cycle as ch_valid[3].
- LOCKED, valid beat with in_sof=1 at slot!=0 (early SOF):
  - sync_err pulses; err_cnt increments.
  - Partial frame is dropped: no frame_valid, staging discarded.
  - Beat is captured as slot 0 (ch_valid[0] pulses), slot<=1, stay LOCKED.
- LOCKED, valid beat with in_sof=0 at slot==0 (missing SOF):
  - sync_err pulses; err_cnt increments.
  - Beat is discarded; go to HUNT, slot<=0.
- Latency: beat accepted at edge N; ch_data, ch_valid, frame_data, frame_valid, sync_err and locked all reflect it after edge N.
- Gaps: in_valid low for any number of cycles holds all state; pulses are 0 during gaps.
- Outputs are held between updates; ch_data is not cleared on error.
- err_cnt saturates at 2^ERR_W-1 and clears only on reset.
- At most one ch_valid bit is set per cycle.
- Reset mid-frame: immediate return to reset values; the first post-reset beat is handled as in HUNT.

Decomposition:
- Shared package tdm_pkg:
  - state enum {HUNT, LOCKED}.
  - NUM_CH=4 constant and slot index type (2 bits).
  - Channel packing helper function.
- One natural sub-module, tdm_slot_ctr: 2-bit wrapping counter with load-to-1 (SOF resync) and clear (drop to HUNT); reused by the transmit-side serializer.
- Capture and staging logic stays in tdm_demux4.

Test Plan:
- Reset then continuous frames: beats A0(sof),A1,A2,A3,B0(sof)..B3 with DATA_W=8 and values 0x10..0x13, 0x20..0x23.
  - Required: locked=1 after the first beat.
  - Required: ch_valid pulses 1,2,4,8 repeating.
  - Required: frame_data=0x13121110 with frame_valid after beat 4, then 0x23222120.
- Hunt discard: beats 0x55,0x66 (sof=0), then a valid frame.
  - Required: no outputs change for the first two beats, err_cnt=0, locked rises on the sof beat.
- Early SOF: 0x10(sof),0x11,0x20(sof),0x21,0x22,0x23.
  - Required: sync_err pulse at the third beat, err_cnt=1, no frame_valid for the partial frame.
  - Required: frame_data=0x23222120 after beat 6.
- Missing SOF: a full frame, then 0x30 with sof=0.
  - Required: sync_err pulse, locked=0, 0x30 not on ch_data.
  - Required: the next sof beat relocks.
- Gaps and reset: in_valid toggling 1,0,0,1 within a frame yields identical frame_data to the gap-free case. Asserting rst_n=0 after slot 2 clears all outputs asynchronously, and the next frame completes normally.
- Saturation with ERR_W=2: 5 missing-SOF errors; err_cnt must read 1,2,3,3,3.
